// File: rtl/fxp_avg_pkg.sv
// Shared types and constants for the fixed-point mean engine.
package fxp_avg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_N,
    ACC,
    DIV,
    WR,
    DONE
  } state_e;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Accumulator width: 255 words of 8*word_bytes bits always fit in 8 extra bits.
  function automatic int sum_w(input int word_bytes);
    return 8 * word_bytes + 8;
  endfunction

endpackage

// File: rtl/fxp_restoring_div.sv
// Restoring divider: one quotient bit per cycle, DVD_W cycles from start_i to the final step.
module fxp_restoring_div #(
  parameter int DVD_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [7:0]       divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] quo_q, quo_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shifted;
  logic signed [9:0] trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[DVD_W-1]};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, dvs_q});
    // done_o marks the cycle whose closing edge produces the last quotient bit
    done_o  = (cnt_q == CNT_W'(1));
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(DVD_W);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (trial < 0) begin
        rem_d = shifted[7:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end else begin
        rem_d = trial[7:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/fxp_avg_engine.sv
// Mean of N big-endian fixed-point words held in byte memory; the result is written after the words.
module fxp_avg_engine
  import fxp_avg_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int FRAC_BITS  = 8,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic              Busy,
  output logic              Err,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemRdData,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int SW     = sum_w(WORD_BYTES);
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  if (FRAC_BITS < 0 || FRAC_BITS > WORD_W || ROUND_MODE < 0 || ROUND_MODE > 1) begin : g_param_check
    $error("fxp_avg_engine: FRAC_BITS or ROUND_MODE out of range");
  end

  function automatic logic [SW-1:0] round_bias(input logic [7:0] n);
    return (ROUND_MODE == ROUND_HALF_UP) ? SW'(n >> 1) : '0;
  endfunction

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [BC_W-1:0]   byte_q, byte_d;
  logic [BC_W-1:0]   wbyte_q, wbyte_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] next_word;
  logic [WORD_W-1:0] res_word;
  logic [SW-1:0]     dividend;
  logic [SW-1:0]     quotient;
  logic              div_start;
  logic              div_done;

  fxp_restoring_div #(
    .DVD_W(SW)
  ) u_div (
    .clk       (Clk),
    .rst_n     (Reset),
    .start_i   (div_start),
    .dividend_i(dividend),
    .divisor_i (n_q),
    .done_o    (div_done),
    .quotient_o(quotient)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wcnt_d    = wcnt_q;
    byte_d    = byte_q;
    wbyte_d   = wbyte_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    word_d    = word_q;
    sum_d     = sum_q;
    err_d     = err_q;
    div_start = 1'b0;
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    next_word = WORD_W'({word_q, MemRdData});
    res_word  = err_q ? '0 : WORD_W'(quotient);

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          MemAddr = BASE;
          sum_d   = '0;
          err_d   = 1'b0;
          state_d = RD_N;
        end
      end
      RD_N: begin
        MemAddr = BASE;
        n_d     = MemRdData;
        wcnt_d  = '0;
        byte_d  = '0;
        wbyte_d = '0;
        phase_d = 1'b0;
        word_d  = '0;
        ptr_d   = BASE + ADDR_W'(1);
        if (MemRdData == 8'd0) begin
          err_d   = 1'b1;
          state_d = WR;
        end else begin
          state_d = ACC;
        end
      end
      // phase 0 presents the byte address, phase 1 captures the returned byte
      ACC: begin
        MemAddr = ptr_q;
        phase_d = ~phase_q;
        if (phase_q) begin
          ptr_d  = ptr_q + ADDR_W'(1);
          word_d = next_word;
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            sum_d  = sum_q + SW'(next_word);
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_q == n_q - 8'd1) begin
              div_start = 1'b1;
              state_d   = DIV;
            end
          end else begin
            byte_d = byte_q + BC_W'(1);
          end
        end
      end
      DIV: begin
        MemAddr = ptr_q;
        if (div_done) state_d = WR;
      end
      WR: begin
        MemAddr   = ptr_q;
        MemWrEn   = 1'b1;
        MemWrData = 8'(res_word >> (int'(WORD_W - 8) - 8 * int'(wbyte_q)));
        ptr_d     = ptr_q + ADDR_W'(1);
        if (wbyte_q == LAST_BYTE) begin
          state_d = DONE;
        end else begin
          wbyte_d = wbyte_q + BC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    dividend = sum_d + round_bias(n_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      byte_q  <= '0;
      wbyte_q <= '0;
      phase_q <= 1'b0;
      ptr_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      byte_q  <= byte_d;
      wbyte_q <= wbyte_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign Ack  = (state_q == DONE);
  assign Busy = (state_q != IDLE) && (state_q != DONE);
  assign Err  = err_q;

endmodule

// File: tb/tb_fxp_avg_engine.sv
// Bench for fxp_avg_engine: truncating and round-half-up instances run side by side on private memories.
module tb_fxp_avg_engine;

  localparam int WB    = 2;
  localparam int SUM_W = 24;
  localparam int MEM   = 1024;
  localparam int BASE  = 0;

  logic       Clk, Reset, Start, load;
  logic       ack0, busy0, err0, we0, ack1, busy1, err1, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] rd0, rd1, wd0, wd1;
  logic [7:0] mem0 [MEM];
  logic [7:0] mem1 [MEM];
  logic [7:0] img  [MEM];
  logic [7:0] exp0 [MEM];
  logic [7:0] exp1 [MEM];

  int unsigned words [256];
  int unsigned res0, res1;
  int checks, errors, cyc, cur_n, cur_L;
  bit run_on, done_flag;

  fxp_avg_engine #(.WORD_BYTES(WB), .FRAC_BITS(8), .ROUND_MODE(0), .ADDR_W(10), .BASE_ADDR(BASE)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(ack0), .Busy(busy0), .Err(err0),
    .MemAddr(addr0), .MemRdData(rd0), .MemWrEn(we0), .MemWrData(wd0));

  fxp_avg_engine #(.WORD_BYTES(WB), .FRAC_BITS(8), .ROUND_MODE(1), .ADDR_W(10), .BASE_ADDR(BASE)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(ack1), .Busy(busy1), .Err(err1),
    .MemAddr(addr1), .MemRdData(rd1), .MemWrEn(we1), .MemWrData(wd1));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (load) begin
      for (int i = 0; i < MEM; i++) begin
        mem0[i] <= img[i];
        mem1[i] <= img[i];
      end
    end else begin
      if (we0) mem0[addr0] <= wd0;
      if (we1) mem1[addr1] <= wd1;
    end
    rd0 <= mem0[addr0];
    rd1 <= mem1[addr1];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int unsigned model_mean(input int n, input int mode);
    longint unsigned s;
    s = 0;
    if (n == 0) return 0;
    for (int i = 0; i < n; i++) s += words[i];
    if (mode == 1) s += longint'(n / 2);
    return int'((s / longint'(n)) & 64'hFFFF);
  endfunction

  function automatic int latency(input int n);
    return (n == 0) ? 2 + WB : 2 + 2 * WB * n + SUM_W + WB;
  endfunction

  task automatic chk_cycle(input string tag, input logic ack, input logic busy, input logic err,
                           input logic we, input logic [9:0] addr, input logic [7:0] wd,
                           input int unsigned res);
    int  k;
    bit  wr_win;
    wr_win = (cyc >= cur_L - WB) && (cyc < cur_L);
    chk({tag, " busy"}, busy, (cyc < cur_L));
    chk({tag, " ack"}, ack, (cyc >= cur_L));
    chk({tag, " wren"}, we, wr_win);
    if (wr_win) begin
      k = cyc - (cur_L - WB);
      chk({tag, " wr addr"}, addr, BASE + WB * cur_n + 1 + k);
      chk({tag, " wr data"}, wd, (res >> (8 * (WB - 1 - k))) & 255);
    end
    if (cyc == cur_L) chk({tag, " err"}, err, (cur_n == 0));
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (run_on) begin
        cyc = cyc + 1;
        chk_cycle("trunc", ack0, busy0, err0, we0, addr0, wd0, res0);
        chk_cycle("round", ack1, busy1, err1, we1, addr1, wd1, res1);
        if (cyc >= cur_L) begin
          done_flag = 1'b1;
          run_on    = 1'b0;
        end
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ack0"}, ack0, 0);
    chk({tag, " busy0"}, busy0, 0);
    chk({tag, " err0"}, err0, 0);
    chk({tag, " wren0"}, we0, 0);
    chk({tag, " addr0"}, addr0, 0);
    chk({tag, " wdata0"}, wd0, 0);
    chk({tag, " ack1"}, ack1, 0);
    chk({tag, " busy1"}, busy1, 0);
    chk({tag, " wren1"}, we1, 0);
  endtask

  task automatic chk_memories(input string tag, input bit use_exp);
    int bad0, bad1;
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < MEM; i++) begin
      if (mem0[i] !== (use_exp ? exp0[i] : img[i])) bad0++;
      if (mem1[i] !== (use_exp ? exp1[i] : img[i])) bad1++;
    end
    chk({tag, " trunc mem bytes differing"}, bad0, 0);
    chk({tag, " round mem bytes differing"}, bad1, 0);
  endtask

  task automatic run(input int n, input bit pulses, input int abort_at);
    bit aborted;
    aborted = 1'b0;
    for (int i = 0; i < MEM; i++) img[i] = 8'($urandom_range(0, 255));
    img[BASE] = 8'(n);
    for (int i = 0; i < n; i++) begin
      img[BASE + 1 + 2 * i] = 8'(words[i] >> 8);
      img[BASE + 2 + 2 * i] = 8'(words[i]);
    end
    res0 = model_mean(n, 0);
    res1 = model_mean(n, 1);
    for (int i = 0; i < MEM; i++) begin
      exp0[i] = img[i];
      exp1[i] = img[i];
    end
    exp0[BASE + 2 * n + 1] = 8'(res0 >> 8);
    exp0[BASE + 2 * n + 2] = 8'(res0);
    exp1[BASE + 2 * n + 1] = 8'(res1 >> 8);
    exp1[BASE + 2 * n + 2] = 8'(res1);
    load = 1'b1;
    @(posedge Clk);
    #1 load = 1'b0;
    @(negedge Clk);
    #1;
    cur_n     = n;
    cur_L     = latency(n);
    cyc       = 0;
    done_flag = 1'b0;
    run_on    = 1'b1;
    Start     = 1'b1;
    for (int k = 0; k < 4000 && !done_flag; k++) begin
      @(negedge Clk);
      #1;
      if (abort_at > 0 && cyc == abort_at) begin
        aborted = 1'b1;
        break;
      end
      Start = pulses && (cyc >= 2) && (cyc <= cur_L - 2) && ($urandom_range(0, 3) == 0);
    end
    Start = 1'b0;
    if (aborted) begin
      run_on = 1'b0;
      Reset  = 1'b0;
      #1;
      chk_idle_outputs("reset mid-acc");
      repeat (3) @(negedge Clk);
      #1;
      chk_idle_outputs("held in reset");
      Reset = 1'b1;
      chk_memories("after abort", 1'b0);
    end else begin
      if (!done_flag) chk("ack within cycle budget", 0, 1);
      run_on = 1'b0;
      chk_memories($sformatf("N=%0d", n), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    run_on = 1'b0;
    load   = 1'b0;
    Start  = 1'b0;
    Reset  = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 9; i++) words[i] = (i + 1) << 8;
    run(9, 1'b0, 0);
    chk("N9 model result", res0, 'h0500);
    chk("N9 latency model", cur_L, 64);
    chk("N9 byte19", mem0[19], 'h05);
    chk("N9 byte20", mem0[20], 'h00);

    words[0] = 'h0100; words[1] = 'h0200; words[2] = 'h0400;
    words[3] = 'h0800; words[4] = 'h1000; words[5] = 'h2000;
    run(6, 1'b1, 0);
    chk("N6 model result", res0, 'h0A80);
    chk("N6 byte13", mem0[13], 'h0A);
    chk("N6 byte14", mem0[14], 'h80);

    words[0] = 'h0000; words[1] = 'h4080; words[2] = 'h8080; words[3] = 'h8080;
    run(4, 1'b0, 0);
    chk("N4 model result", res0, 'h5060);
    chk("N4 byte9", mem0[9], 'h50);
    chk("N4 byte10", mem0[10], 'h60);

    words[0] = 'h0002; words[1] = 'h0000; words[2] = 'h0000;
    run(3, 1'b0, 0);
    chk("N3 trunc model", res0, 'h0000);
    chk("N3 round model", res1, 'h0001);
    chk("N3 trunc byte8", mem0[8], 'h00);
    chk("N3 round byte7", mem1[7], 'h00);
    chk("N3 round byte8", mem1[8], 'h01);

    run(0, 1'b0, 0);
    chk("N0 byte1", mem0[1], 'h00);
    chk("N0 byte2", mem0[2], 'h00);
    chk("N0 err held", err0, 1);

    words[0] = 'h0100; words[1] = 'h0300;
    run(2, 1'b0, 0);
    chk("N2 model result", res0, 'h0200);
    chk("N2 byte5", mem0[5], 'h02);
    chk("N2 byte6", mem0[6], 'h00);
    chk("N2 err cleared", err0, 0);

    for (int i = 0; i < 5; i++) words[i] = $urandom_range(0, 'hFFFF);
    run(5, 1'b0, 6);
    run(5, 1'b1, 0);

    for (int i = 0; i < 255; i++) words[i] = 'hFFFF;
    run(255, 1'b0, 0);
    chk("N255 max model", res0, 'hFFFF);
    chk("N255 byte511", mem0[511], 'hFF);

    words[0] = $urandom_range(0, 'hFFFF);
    run(1, 1'b1, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) words[i] = $urandom_range(0, 'hFFFF);
      run(n, 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
